// File: rtl/tsq_pkg.sv
// tsq_pkg -- shared definitions for the timestamp-queue reader.
//   state_t      : reader FSM state encoding
//   DIR_RX/DIR_TX: entry source / queue selector values (ts_dir, round-robin pointer)
//   POP_RX/POP_TX: values written to the queue control register to pop one entry
//   TMR_W        : width of the latency / poll-gap down-counter
package tsq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STAT_RD,
    ST_STAT_WT,
    ST_POP,
    ST_DATA_RD,
    ST_DATA_WT,
    ST_OUT,
    ST_GAP
  } state_t;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  localparam logic [31:0] POP_RX = 32'h0000_0001;
  localparam logic [31:0] POP_TX = 32'h0000_0002;

  localparam int TMR_W = 16;

  // Pop command word for the queue selected by dir.
  function automatic logic [31:0] pop_code(input logic dir);
    return (dir == DIR_TX) ? POP_TX : POP_RX;
  endfunction

endpackage

// File: rtl/tsq_rd_timer.sv
// tsq_rd_timer -- down-counter shared by the read-latency wait and the
// idle gap after an empty poll.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val (takes priority over counting)
//   load_val : number of cycles to count, the first counted cycle being the
//              one after load
//   done     : high in the last counted cycle (count reached 1) and while idle
module tsq_rd_timer
  import tsq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);

  logic [TMR_W-1:0] cnt_reg;
  logic [TMR_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // A load of N gives N cycles with counts N..1; done marks the count of 1.
  assign done = (cnt_reg == TMR_W'(1)) || (cnt_reg == '0);

endmodule

// File: rtl/tsq_reader.sv
// tsq_reader -- polls the RX and TX timestamp queues of a timestamp unit
// round-robin over its register port, pops non-empty queues and presents
// each 128-bit entry on a valid/ready stream.
//   clk, rst          : clock, synchronous active-high reset
//   enable            : allow new polls (a started entry always completes)
//   wr_out, rd_out    : one-cycle register write / read strobes
//   addr_out, data_out: register address and write data (held between strobes)
//   data_in           : read data, valid RD_LATENCY cycles after rd_out
//   ts_valid/ts_ready : entry handshake; ts_dir 0=RX 1=TX; ts_data word k at [32k+31:32k]
//   rx_cnt, tx_cnt    : delivered-entry counters (saturating), built only when
//                       TSQ_READER_CNT_EN is defined, otherwise tied to 0
module tsq_reader
  import tsq_pkg::*;
#(
  parameter logic [7:0] RX_STAT_ADDR = 8'h40,
  parameter logic [7:0] RX_DATA_ADDR = 8'h44,
  parameter logic [7:0] TX_STAT_ADDR = 8'h60,
  parameter logic [7:0] TX_DATA_ADDR = 8'h64,
  parameter logic [7:0] QCTL_ADDR    = 8'h3C,
  parameter int         RD_LATENCY   = 2,
  parameter int         POLL_GAP     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic         wr_out,
  output logic         rd_out,
  output logic [7:0]   addr_out,
  output logic [31:0]  data_out,
  input  logic [31:0]  data_in,
  output logic         ts_valid,
  input  logic         ts_ready,
  output logic         ts_dir,
  output logic [127:0] ts_data,
  output logic [15:0]  rx_cnt,
  output logic [15:0]  tx_cnt
);

  state_t           state_reg, state_next;
  logic             q_reg, q_next;
  logic [1:0]       k_reg, k_next;
  logic [7:0]       addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic             dir_reg;
  logic             dir_we;
  logic             word_we;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic             handshake;
  logic [7:0]       data_base;
  logic [1:0]       k_inc;

  tsq_rd_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign data_base = (q_reg == DIR_TX) ? TX_DATA_ADDR : RX_DATA_ADDR;
  assign k_inc     = k_reg + 2'd1;
  assign handshake = (state_reg == ST_OUT) && ts_ready;

  // Next-state logic. addr/data are computed one cycle ahead, on the
  // transition into a strobe state, so they are registered and stable in the
  // strobe cycle and simply hold afterwards.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    k_next     = k_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    tmr_load   = 1'b0;
    tmr_val    = TMR_W'(RD_LATENCY);
    word_we    = 1'b0;
    dir_we     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_STAT_RD;
          addr_next  = (q_reg == DIR_TX) ? TX_STAT_ADDR : RX_STAT_ADDR;
        end
      end
      ST_STAT_RD: begin
        tmr_load   = 1'b1;
        state_next = ST_STAT_WT;
      end
      ST_STAT_WT: begin
        if (tmr_done) begin
          if (data_in[7:0] != 8'h00) begin
            state_next = ST_POP;
            addr_next  = QCTL_ADDR;
            wdata_next = pop_code(q_reg);
          end else begin
            state_next = ST_GAP;
            tmr_load   = 1'b1;
            tmr_val    = TMR_W'(POLL_GAP);
          end
        end
      end
      ST_POP: begin
        dir_we     = 1'b1;
        k_next     = 2'd0;
        addr_next  = data_base;
        state_next = ST_DATA_RD;
      end
      ST_DATA_RD: begin
        tmr_load   = 1'b1;
        state_next = ST_DATA_WT;
      end
      ST_DATA_WT: begin
        if (tmr_done) begin
          word_we = 1'b1;
          if (k_reg == 2'd3) begin
            state_next = ST_OUT;
          end else begin
            k_next     = k_inc;
            addr_next  = data_base + {4'b0000, k_inc, 2'b00};
            state_next = ST_DATA_RD;
          end
        end
      end
      ST_OUT: begin
        if (ts_ready) begin
          q_next     = ~q_reg;
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          q_next     = ~q_reg;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      q_reg     <= DIR_RX;
      k_reg     <= 2'd0;
      addr_reg  <= 8'h00;
      wdata_reg <= 32'h0;
      dir_reg   <= DIR_RX;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      k_reg     <= k_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      if (dir_we) begin
        dir_reg <= q_reg;
      end
    end
  end

  // Entry words are captured straight into the output register; ts_valid
  // stays low until all four are in, and nothing clears them on handshake.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    logic [31:0] word_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        word_reg <= 32'h0;
      end else if (word_we && (k_reg == 2'(gi))) begin
        word_reg <= data_in;
      end
    end
    assign ts_data[32*gi +: 32] = word_reg;
  end

  assign rd_out   = (state_reg == ST_STAT_RD) || (state_reg == ST_DATA_RD);
  assign wr_out   = (state_reg == ST_POP);
  assign addr_out = addr_reg;
  assign data_out = wdata_reg;
  assign ts_valid = (state_reg == ST_OUT);
  assign ts_dir   = dir_reg;

`ifdef TSQ_READER_CNT_EN
  logic [15:0] rx_cnt_reg;
  logic [15:0] tx_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_reg <= 16'h0;
      tx_cnt_reg <= 16'h0;
    end else if (handshake) begin
      if (dir_reg == DIR_RX) begin
        if (rx_cnt_reg != 16'hFFFF) rx_cnt_reg <= rx_cnt_reg + 16'd1;
      end else begin
        if (tx_cnt_reg != 16'hFFFF) tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end
    end
  end

  assign rx_cnt = rx_cnt_reg;
  assign tx_cnt = tx_cnt_reg;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign rx_cnt = 16'h0;
  assign tx_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_tsq_reader.sv
// tb_tsq_reader -- bench for tsq_reader. Three instances (RD_LATENCY 2, 1, 7)
// each talk to a small timestamp-unit register model that returns read data
// exactly RD_LATENCY cycles after rd_out and garbage in every other cycle.
module tb_tsq_reader;
  localparam int LAT [3] = '{2, 1, 7};

  logic         clk = 1'b0;
  logic         rst;
  logic         enable   [3];
  logic         ts_ready [3];
  logic         wr       [3];
  logic         rd       [3];
  logic [7:0]   addr     [3];
  logic [31:0]  dout     [3];
  logic [31:0]  din      [3];
  logic         ts_valid [3];
  logic         ts_dir   [3];
  logic [127:0] tsd      [3];
  logic [15:0]  rxc      [3];
  logic [15:0]  txc      [3];

  always #5 clk = ~clk;

  tsq_reader #(.RD_LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .enable(enable[0]), .wr_out(wr[0]), .rd_out(rd[0]),
    .addr_out(addr[0]), .data_out(dout[0]), .data_in(din[0]), .ts_valid(ts_valid[0]),
    .ts_ready(ts_ready[0]), .ts_dir(ts_dir[0]), .ts_data(tsd[0]), .rx_cnt(rxc[0]), .tx_cnt(txc[0]));
  tsq_reader #(.RD_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .enable(enable[1]), .wr_out(wr[1]), .rd_out(rd[1]),
    .addr_out(addr[1]), .data_out(dout[1]), .data_in(din[1]), .ts_valid(ts_valid[1]),
    .ts_ready(ts_ready[1]), .ts_dir(ts_dir[1]), .ts_data(tsd[1]), .rx_cnt(rxc[1]), .tx_cnt(txc[1]));
  tsq_reader #(.RD_LATENCY(7)) u2 (
    .clk(clk), .rst(rst), .enable(enable[2]), .wr_out(wr[2]), .rd_out(rd[2]),
    .addr_out(addr[2]), .data_out(dout[2]), .data_in(din[2]), .ts_valid(ts_valid[2]),
    .ts_ready(ts_ready[2]), .ts_dir(ts_dir[2]), .ts_data(tsd[2]), .rx_cnt(rxc[2]), .tx_cnt(txc[2]));

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Register model state. pushed is written only by the stimulus, popped/cur
  // only by the bus model.
  int          pushed [3][2] = '{default: 0};
  int          popped [3][2] = '{default: 0};
  int          cur    [3][2] = '{default: 0};
  int          stat_reads     [3] = '{default: 0};
  int          last_stat_cyc  [3] = '{default: 0};
  logic [7:0]  last_stat_addr [3] = '{default: 8'h00};
  int          wr_count       [3] = '{default: 0};
  logic [7:0]  last_wr_addr   [3] = '{default: 8'h00};
  logic [31:0] last_wr_data   [3] = '{default: 32'h0};
  logic        pv [3][8] = '{default: 1'b0};
  logic [31:0] pd [3][8] = '{default: 32'h0};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entry word k of the n-th entry of queue q.
  function automatic logic [31:0] word(input int q, input int n, input int k);
    logic [31:0] m;
    m = 32'h1111_1111 * 32'(k + 1);
    return m ^ {(q != 0) ? 8'hF0 : 8'h00, 8'(n), 16'h0000};
  endfunction

  function automatic logic [31:0] regread(input int i, input logic [7:0] a);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    if (a == 8'h40) r = {24'h0, 8'(pushed[i][0] - popped[i][0])};
    else if (a == 8'h60) r = {24'h0, 8'(pushed[i][1] - popped[i][1])};
    else if (a >= 8'h44 && a <= 8'h50 && a[1:0] == 2'b00) r = word(0, cur[i][0], int'((a - 8'h44) >> 2));
    else if (a >= 8'h64 && a <= 8'h70 && a[1:0] == 2'b00) r = word(1, cur[i][1], int'((a - 8'h64) >> 2));
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      din[i] = pv[i][LAT[i]-1] ? pd[i][LAT[i]-1] : 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      for (int s = 7; s > 0; s--) begin
        pv[i][s] <= pv[i][s-1];
        pd[i][s] <= pd[i][s-1];
      end
      pv[i][0] <= rd[i];
      pd[i][0] <= regread(i, addr[i]);
      if (rd[i] || wr[i]) begin
        logic busy;
        busy = 1'b0;
        for (int s = 0; s < LAT[i] - 1; s++) if (pv[i][s]) busy = 1'b1;
        check("strobe_exclusive", {126'h0, rd[i] && wr[i], rd[i] && busy}, 128'h0);
      end
      if (wr[i]) begin
        check("pop_addr", {120'h0, addr[i]}, {120'h0, 8'h3C});
        if (dout[i] == 32'h1 || dout[i] == 32'h2) begin
          int q;
          q = (dout[i] == 32'h2) ? 1 : 0;
          cur[i][q] = popped[i][q];
          popped[i][q]++;
        end
        wr_count[i]++;
        last_wr_addr[i] = addr[i];
        last_wr_data[i] = dout[i];
      end
      if (rd[i] && (addr[i] == 8'h40 || addr[i] == 8'h60)) begin
        stat_reads[i]++;
        last_stat_cyc[i]  = cyc;
        last_stat_addr[i] = addr[i];
      end
    end
  end

  task automatic run_entry(input int i, input int rdelay, input logic exp_dir,
                           input logic [127:0] exp_data, input logic [31:0] exp_pop, input int exp_lat);
    bit ok;
    int lat;
    ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge clk);
      if (ts_valid[i]) ok = 1'b1;
    end
    check("valid_timeout", {127'h0, ok}, 128'h1);
    if (!ok) return;
    lat = cyc - last_stat_cyc[i];
    check("latency", 128'(lat), 128'(exp_lat));
    check("ts_dir", {127'h0, ts_dir[i]}, {127'h0, exp_dir});
    check("ts_data", tsd[i], exp_data);
    check("pop_write", {88'h0, last_wr_addr[i], last_wr_data[i]}, {88'h0, 8'h3C, exp_pop});
    for (int d = 0; d < rdelay; d++) begin
      @(negedge clk);
      check("hold_valid", {127'h0, ts_valid[i]}, 128'h1);
      check("hold_data", tsd[i], exp_data);
      check("hold_no_strobe", {126'h0, rd[i], wr[i]}, 128'h0);
    end
    ts_ready[i] = 1'b1;
    @(negedge clk);
    ts_ready[i] = 1'b0;
    check("valid_drop", {127'h0, ts_valid[i]}, 128'h0);
    check("data_kept", tsd[i], exp_data);
    $display("[TB] inst %0d entry dir=%0d lat=%0d data=%h", i, ts_dir[i], lat, tsd[i]);
  endtask

  task automatic wait_stat(input int i, output int c, output logic [7:0] a);
    int s0;
    bit ok;
    s0 = stat_reads[i];
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (stat_reads[i] != s0) ok = 1'b1;
    end
    check("stat_timeout", {127'h0, ok}, 128'h1);
    c = last_stat_cyc[i];
    a = last_stat_addr[i];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"}, {127'h0, rd[0]}, 128'h0);
    check({tag, "_wr"}, {127'h0, wr[0]}, 128'h0);
    check({tag, "_addr"}, {120'h0, addr[0]}, 128'h0);
    check({tag, "_wdata"}, {96'h0, dout[0]}, 128'h0);
    check({tag, "_valid"}, {127'h0, ts_valid[0]}, 128'h0);
    check({tag, "_dir"}, {127'h0, ts_dir[0]}, 128'h0);
    check({tag, "_data"}, tsd[0], 128'h0);
    check({tag, "_cnt"}, {96'h0, rxc[0], txc[0]}, 128'h0);
  endtask

  typedef struct {
    int           rdelay;
    logic         dir;
    logic [127:0] data;
    logic [31:0]  pop;
    int           lat;
  } vec_t;

  vec_t tbl [3];

  initial begin
    int c1, c2, c3, wc0, sr0;
    logic [7:0] a1, a2, a3;
    bit ok;

    tbl[0] = '{0,  1'b0, 128'h44444444_33333333_22222222_11111111, 32'h1, 16};
    tbl[1] = '{20, 1'b1, 128'hB4444444_C3333333_D2222222_E1111111, 32'h2, 16};
    tbl[2] = '{3,  1'b0, 128'h44454444_33323333_22232222_11101111, 32'h1, 16};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enable[i]   = 1'b0;
      ts_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Both queues non-empty: RX, TX, RX with varied consumer back-pressure.
    pushed[0][0] = 2;
    pushed[0][1] = 1;
    enable[0] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      run_entry(0, tbl[r].rdelay, tbl[r].dir, tbl[r].data, tbl[r].pop, tbl[r].lat);
    end

    // Both queues empty: alternating stat polls 1+2+16+1 = 20 cycles apart.
    wc0 = wr_count[0];
    wait_stat(0, c1, a1);
    wait_stat(0, c2, a2);
    wait_stat(0, c3, a3);
    check("gap_period_1", 128'(c2 - c1), 128'd20);
    check("gap_period_2", 128'(c3 - c2), 128'd20);
    check("poll_alternates", {126'h0, a1 != a2, a1 == a3}, 128'h3);
    check("no_pop_when_empty", 128'(wr_count[0]), 128'(wc0));
`ifdef TSQ_READER_CNT_EN
    check("counters", {96'h0, rxc[0], txc[0]}, {96'h0, 16'd2, 16'd1});
`else
    check("counters", {96'h0, rxc[0], txc[0]}, 128'h0);
`endif

    // Reset in the wait for TX word 2: partial entry discarded, RX polled next.
    pushed[0][1] = 2;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (rd[0] && addr[0] == 8'h6C) ok = 1'b1;
    end
    check("word2_timeout", {127'h0, ok}, 128'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    wait_stat(0, c1, a1);
    check("poll_after_reset", {120'h0, a1}, {120'h0, 8'h40});

    // Drop enable once the pop is issued: the entry still arrives, then silence.
    pushed[0][0] = 3;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (wr[0]) ok = 1'b1;
    end
    check("pop_timeout", {127'h0, ok}, 128'h1);
    enable[0] = 1'b0;
    run_entry(0, 0, 1'b0, 128'h44464444_33313333_22202222_11131111, 32'h1, 16);
    sr0 = stat_reads[0];
    repeat (60) @(negedge clk);
    check("no_poll_disabled", 128'(stat_reads[0]), 128'(sr0));

    // Other read latencies: 1+L+1+4(1+L) = 11 for L=1, 41 for L=7.
    for (int i = 1; i < 3; i++) begin
      pushed[i][0] = 1;
      enable[i] = 1'b1;
      run_entry(i, 2, 1'b0, 128'h44444444_33333333_22222222_11111111, 32'h1, (i == 1) ? 11 : 41);
      enable[i] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
